// File: rtl/st7735_pkg.sv
// Shared definitions for the ST7735 panel driver: command opcodes, FSM
// states, init-ROM entry layout, init-ROM contents and colour-bar palette.
package st7735_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [1:0] {HW_RESET, WAIT, INIT, FRAME} state_t;

  // is_delay: hold off DELAY_CYCLES after this byte has been shifted out
  typedef struct packed {
    logic       is_data;
    logic       is_delay;
    logic [7:0] byte_val;
  } rom_entry_t;

  localparam int INIT_LEN = 7;

  localparam logic [15:0] COLOR_WHITE   = 16'hFFFF;
  localparam logic [15:0] COLOR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COLOR_CYAN    = 16'h07FF;
  localparam logic [15:0] COLOR_GREEN   = 16'h07E0;
  localparam logic [15:0] COLOR_MAGENTA = 16'hF81F;
  localparam logic [15:0] COLOR_RED     = 16'hF800;
  localparam logic [15:0] COLOR_BLUE    = 16'h001F;
  localparam logic [15:0] COLOR_BLACK   = 16'h0000;

  // Index 0 is the leftmost bar
  localparam logic [7:0][15:0] BAR_COLORS = {
    COLOR_BLACK, COLOR_BLUE, COLOR_RED, COLOR_MAGENTA,
    COLOR_GREEN, COLOR_CYAN, COLOR_YELLOW, COLOR_WHITE
  };

  function automatic rom_entry_t init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return '{is_data: 1'b0, is_delay: 1'b1, byte_val: CMD_SWRESET};
      3'd1:    return '{is_data: 1'b0, is_delay: 1'b1, byte_val: CMD_SLPOUT};
      3'd2:    return '{is_data: 1'b0, is_delay: 1'b0, byte_val: CMD_COLMOD};
      3'd3:    return '{is_data: 1'b1, is_delay: 1'b0, byte_val: 8'h05};
      3'd4:    return '{is_data: 1'b0, is_delay: 1'b0, byte_val: CMD_MADCTL};
      3'd5:    return '{is_data: 1'b1, is_delay: 1'b0, byte_val: 8'h00};
      3'd6:    return '{is_data: 1'b0, is_delay: 1'b0, byte_val: CMD_DISPON};
      default: return '{is_data: 1'b0, is_delay: 1'b0, byte_val: 8'h00};
    endcase
  endfunction

endpackage

// File: rtl/st7735_if.sv
// Panel-side pin bundle of the ST7735 driver (RESX plus 4-wire SPI).
interface st7735_if;
  logic reset;
  logic spi_cs;
  logic spi_dc;
  logic spi_clk;
  logic spi_mosi;

  modport master (output reset, spi_cs, spi_dc, spi_clk, spi_mosi);
  modport slave  (input  reset, spi_cs, spi_dc, spi_clk, spi_mosi);
endinterface

// File: rtl/st7735_spi_tx.sv
// SPI mode-0 byte serializer. A byte occupies 17*CLK_DIV clk cycles:
// 16 half-periods with CS low (8 SCK pulses, low phase first) followed by
// CLK_DIV cycles of CS high. A new start is accepted in the last gap cycle
// so back-to-back bytes keep that exact period.
module st7735_spi_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       dc,
  output logic       busy,
  output logic       done,
  output logic       spi_cs,
  output logic       spi_dc,
  output logic       spi_clk,
  output logic       spi_mosi
);

  logic        active;
  logic [4:0]  half;
  logic [15:0] div;
  logic [7:0]  shreg;
  logic        cs_q, dc_q, sck_q, mosi_q;
  logic        div_end;

  assign div_end  = (div == 16'(CLK_DIV - 1));
  assign done     = active && (half == 5'd16) && div_end;
  assign busy     = active && !done;
  assign spi_cs   = cs_q;
  assign spi_dc   = dc_q;
  assign spi_clk  = sck_q;
  assign spi_mosi = mosi_q;

  // Half-period sequencer: SCK follows half parity, MOSI shifts on SCK fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      half   <= '0;
      div    <= '0;
      shreg  <= '0;
      cs_q   <= 1'b1;
      dc_q   <= 1'b0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
    end else if (start && !busy) begin
      active <= 1'b1;
      half   <= '0;
      div    <= '0;
      shreg  <= {tx_byte[6:0], 1'b0};
      mosi_q <= tx_byte[7];
      dc_q   <= dc;
      cs_q   <= 1'b0;
      sck_q  <= 1'b0;
    end else if (active) begin
      if (div_end) begin
        div <= '0;
        if (half == 5'd16) begin
          active <= 1'b0;
          half   <= '0;
        end else begin
          half <= half + 5'd1;
          if (half == 5'd15) begin
            sck_q <= 1'b0;
            cs_q  <= 1'b1;
          end else begin
            sck_q <= ~half[0];
            if (half[0]) begin
              mosi_q <= shreg[7];
              shreg  <= {shreg[6:0], 1'b0};
            end
          end
        end
      end else begin
        div <= div + 16'd1;
      end
    end
  end

endmodule

// File: rtl/st7735.sv
// ST7735 128x160 TFT driver: panel reset pulse, init command ROM, then an
// endless stream of RGB565 frames. Define ST7735_COLORBAR_EN for 8 vertical
// colour bars; otherwise every pixel is solid blue.
module st7735 #(
  parameter int CLK_DIV      = 2,
  parameter int RESET_CYCLES = 1000,
  parameter int DELAY_CYCLES = 2000,
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 160
) (
  input  logic clk,
  input  logic rst,
  st7735_if.master bus
);
  import st7735_pkg::*;

`ifdef ST7735_COLORBAR_EN
  localparam bit BARS_EN = 1'b1;
`else
  localparam bit BARS_EN = 1'b0;
`endif

  localparam int BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;

  function automatic logic [15:0] pixel_color(input logic [7:0] col);
    int bar;
    bar = int'(col) / BAR_W;
    if (bar > 7) bar = 7;
    return BARS_EN ? BAR_COLORS[bar[2:0]] : COLOR_BLUE;
  endfunction

  // Address-window header as {dc, byte}; idx 10 is RAMWR
  function automatic logic [8:0] frame_hdr(input logic [3:0] idx);
    case (idx)
      4'd0:    return {1'b0, CMD_CASET};
      4'd4:    return {1'b1, 8'(WIDTH - 1)};
      4'd5:    return {1'b0, CMD_RASET};
      4'd9:    return {1'b1, 8'(HEIGHT - 1)};
      4'd10:   return {1'b0, CMD_RAMWR};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  state_t     state;
  logic [31:0] cnt;
  logic       reset_q;
  logic [2:0] rom_idx;
  logic [3:0] hdr_idx;
  logic [7:0] x, y;
  logic       in_pix, pix_lo, dly_arm, dly_run;
  logic       tx_valid, tx_dc, tx_delay;
  logic [7:0] tx_byte;
  logic       tx_busy, tx_done, accept;
  rom_entry_t rom_cur, rom_nxt;
  logic [8:0] hdr_nxt;
  logic [15:0] col_cur, col_nxt, col_first;

  assign rom_cur   = init_rom(rom_idx);
  assign rom_nxt   = init_rom(rom_idx + 3'd1);
  assign hdr_nxt   = frame_hdr(hdr_idx + 4'd1);
  assign col_cur   = pixel_color(x);
  assign col_nxt   = pixel_color(x + 8'd1);
  assign col_first = pixel_color(8'd0);
  assign accept    = tx_valid && !tx_busy;
  assign bus.reset = reset_q;

  st7735_spi_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (tx_valid),
    .tx_byte  (tx_byte),
    .dc       (tx_dc),
    .busy     (tx_busy),
    .done     (tx_done),
    .spi_cs   (bus.spi_cs),
    .spi_dc   (bus.spi_dc),
    .spi_clk  (bus.spi_clk),
    .spi_mosi (bus.spi_mosi)
  );

  // Sequencer: stages the next byte into tx_* each time the serializer takes one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HW_RESET;
      cnt      <= '0;
      reset_q  <= 1'b0;
      rom_idx  <= '0;
      hdr_idx  <= '0;
      x        <= '0;
      y        <= '0;
      in_pix   <= 1'b0;
      pix_lo   <= 1'b0;
      dly_arm  <= 1'b0;
      dly_run  <= 1'b0;
      tx_valid <= 1'b0;
      tx_dc    <= 1'b0;
      tx_delay <= 1'b0;
      tx_byte  <= '0;
    end else begin
      case (state)
        HW_RESET: begin
          if (cnt == 32'(RESET_CYCLES - 1)) begin
            cnt     <= '0;
            reset_q <= 1'b1;
            state   <= WAIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WAIT: begin
          if (cnt == 32'(DELAY_CYCLES - 1)) begin
            cnt      <= '0;
            state    <= INIT;
            tx_valid <= 1'b1;
            {tx_dc, tx_delay, tx_byte} <= rom_cur;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        INIT: begin
          if (dly_run) begin
            if (cnt == 32'(DELAY_CYCLES - 1)) begin
              cnt      <= '0;
              dly_run  <= 1'b0;
              tx_valid <= 1'b1;
              {tx_dc, tx_delay, tx_byte} <= rom_cur;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end else if (dly_arm) begin
            // Delay counts from the end of the byte, not from its launch
            if (tx_done) begin
              dly_arm <= 1'b0;
              dly_run <= 1'b1;
              cnt     <= '0;
            end
          end else if (accept) begin
            if (rom_idx == 3'(INIT_LEN - 1)) begin
              state    <= FRAME;
              hdr_idx  <= '0;
              in_pix   <= 1'b0;
              tx_delay <= 1'b0;
              {tx_dc, tx_byte} <= frame_hdr(4'd0);
            end else if (tx_delay) begin
              tx_valid <= 1'b0;
              dly_arm  <= 1'b1;
              rom_idx  <= rom_idx + 3'd1;
            end else begin
              rom_idx <= rom_idx + 3'd1;
              {tx_dc, tx_delay, tx_byte} <= rom_nxt;
            end
          end
        end
        FRAME: begin
          if (accept) begin
            if (!in_pix) begin
              if (hdr_idx == 4'd10) begin
                in_pix  <= 1'b1;
                pix_lo  <= 1'b0;
                x       <= '0;
                y       <= '0;
                tx_dc   <= 1'b1;
                tx_byte <= col_first[15:8];
              end else begin
                hdr_idx <= hdr_idx + 4'd1;
                {tx_dc, tx_byte} <= hdr_nxt;
              end
            end else if (!pix_lo) begin
              pix_lo  <= 1'b1;
              tx_byte <= col_cur[7:0];
            end else begin
              pix_lo <= 1'b0;
              if (x == 8'(WIDTH - 1)) begin
                x <= '0;
                if (y == 8'(HEIGHT - 1)) begin
                  y       <= '0;
                  in_pix  <= 1'b0;
                  hdr_idx <= '0;
                  {tx_dc, tx_byte} <= frame_hdr(4'd0);
                end else begin
                  y       <= y + 8'd1;
                  tx_byte <= col_first[15:8];
                end
              end else begin
                x       <= x + 8'd1;
                tx_byte <= col_nxt[15:8];
              end
            end
          end
        end
        default: state <= HW_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_st7735.sv
// Self-checking bench for st7735 with a reduced panel (16x4) and short
// reset/delay times. A negedge monitor decodes SPI bytes and checks timing.
module tb_st7735;

  localparam int CD  = 2;
  localparam int RC  = 20;
  localparam int DLY = 40;
  localparam int W   = 16;
  localparam int H   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  st7735_if bus_if ();

  st7735 #(.CLK_DIV(CD), .RESET_CYCLES(RC), .DELAY_CYCLES(DLY),
           .WIDTH(W), .HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         dc;
    logic [7:0] b;
    int         fall;
    int         rise;
  } cap_t;
  cap_t cap[$];

  int    viol = 0;
  string first_viol = "";
  int    sck_rises = 0;
  logic  p_cs = 1'b1, p_sck = 1'b0, p_mosi = 1'b0, p_dc = 1'b0;
  int    bits = 0;
  logic [7:0] sh = '0;
  int    last_fall = -1, low_start = 0, hi_start = 0;

  task automatic note(input string s);
    if (viol == 0) first_viol = s;
    viol++;
  endtask

  // SPI decoder and protocol monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    if (rst) begin
      bits = 0;
      last_fall = -1;
      cap.delete();
    end else begin
      if (p_cs && !bus_if.spi_cs) begin
        if (last_fall >= 0 && !((cyc - last_fall) == 17*CD || (cyc - last_fall) >= 17*CD + DLY))
          note("byte_period");
        if (bus_if.spi_clk) note("sck_at_cs_fall");
        last_fall = cyc; low_start = cyc; bits = 0; sh = '0;
      end
      if (!p_sck && bus_if.spi_clk) begin
        sck_rises++;
        if (bus_if.spi_cs) note("sck_while_cs_high");
        if (bus_if.spi_mosi !== p_mosi) note("mosi_unstable");
        if (cyc - low_start != CD) note("sck_low_time");
        sh = {sh[6:0], bus_if.spi_mosi};
        bits++;
        hi_start = cyc;
      end
      if (p_sck && !bus_if.spi_clk) begin
        if (cyc - hi_start != CD) note("sck_high_time");
        low_start = cyc;
      end
      if (!p_cs && bus_if.spi_cs) begin
        if (bits != 8) note("bit_count");
        if (cyc - last_fall != 16*CD) note("cs_low_time");
        if (bus_if.spi_clk) note("sck_at_cs_rise");
        cap.push_back('{dc: bus_if.spi_dc, b: sh, fall: last_fall, rise: cyc});
      end
      if (bus_if.spi_dc !== p_dc && !p_cs) note("dc_change_cs_low");
    end
    p_cs = bus_if.spi_cs; p_sck = bus_if.spi_clk;
    p_mosi = bus_if.spi_mosi; p_dc = bus_if.spi_dc;
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cap(input int n, input int budget, output bit ok);
    int k = 0;
    ok = 1'b1;
    while (cap.size() < n) begin
      @(posedge clk);
      k++;
      if (k >= budget) begin ok = 1'b0; break; end
    end
  endtask

  task automatic measure_reset(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus_if.reset && n < 1000);
  endtask

`ifdef ST7735_COLORBAR_EN
  localparam logic [15:0] BAR_TAB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  localparam logic [15:0] EXP_X0 = 16'hFFFF, EXP_X2 = 16'hFFE0, EXP_X15 = 16'h0000;
  function automatic logic [15:0] exp_pix(input int xx);
    return BAR_TAB[3'(xx / (W / 8))];
  endfunction
`else
  localparam logic [15:0] EXP_X0 = 16'h001F, EXP_X2 = 16'h001F, EXP_X15 = 16'h001F;
  function automatic logic [15:0] exp_pix(input int xx);
    return (xx >= 0) ? 16'h001F : 16'h001F;
  endfunction
`endif

  typedef struct {
    string      name;
    bit         dc;
    logic [7:0] b;
  } vec_t;
  vec_t exp_tab[18];

  initial begin
    int n, idx, bad, k;
    bit ok;
    logic [15:0] e, pix;
    logic [7:0] eb;

    exp_tab = '{
      '{"C01", 1'b0, 8'h01}, '{"C11", 1'b0, 8'h11}, '{"C3A", 1'b0, 8'h3A},
      '{"D05", 1'b1, 8'h05}, '{"C36", 1'b0, 8'h36}, '{"D00m", 1'b1, 8'h00},
      '{"C29", 1'b0, 8'h29}, '{"C2A", 1'b0, 8'h2A}, '{"CA0", 1'b1, 8'h00},
      '{"CA1", 1'b1, 8'h00}, '{"CA2", 1'b1, 8'h00}, '{"CA3", 1'b1, 8'h0F},
      '{"C2B", 1'b0, 8'h2B}, '{"RA0", 1'b1, 8'h00}, '{"RA1", 1'b1, 8'h00},
      '{"RA2", 1'b1, 8'h00}, '{"RA3", 1'b1, 8'h03}, '{"C2C", 1'b0, 8'h2C}
    };

    // Reset values
    repeat (5) @(posedge clk);
    #1;
    check("rst_reset", 32'(bus_if.reset), 32'd0);
    check("rst_cs", 32'(bus_if.spi_cs), 32'd1);
    check("rst_sck", 32'(bus_if.spi_clk), 32'd0);
    check("rst_mosi", 32'(bus_if.spi_mosi), 32'd0);
    check("rst_dc", 32'(bus_if.spi_dc), 32'd0);

    @(negedge clk); #1 rst = 1'b0;
    measure_reset(n);
    check("reset_rise_cycles", 32'(n), 32'(RC));
    k = 0;
    while (bus_if.spi_cs && k < 1000) begin
      @(posedge clk); #1; n++; k++;
    end
    tests++;
    if (n < RC + DLY - 1 || n > RC + DLY + 1) begin
      fails++;
      $display("FAIL first_cs_fall: got %0d cycles, expected %0d..%0d", n, RC + DLY - 1, RC + DLY + 1);
    end

    // Init sequence, first header, one full frame, second header
    wait_cap(18 + 2*W*H + 11, 20000, ok);
    check("wait_first_frame", 32'(ok), 32'd1);
    for (int i = 0; i < 18; i++)
      check({"seq_", exp_tab[i].name}, {23'd0, cap[i].dc, cap[i].b}, {23'd0, exp_tab[i].dc, exp_tab[i].b});

    tests++;
    if (cap[1].fall - cap[0].rise < DLY) begin
      fails++;
      $display("FAIL delay_after_C01: got %0d cycles, expected >= %0d", cap[1].fall - cap[0].rise, DLY);
    end
    tests++;
    if (cap[2].fall - cap[1].rise < DLY) begin
      fails++;
      $display("FAIL delay_after_C11: got %0d cycles, expected >= %0d", cap[2].fall - cap[1].rise, DLY);
    end

    idx = 18;
    while (idx < cap.size() && cap[idx].dc) idx++;
    check("pixel_byte_count", 32'(idx - 18), 32'(2*W*H));

    pix = {cap[18].b, cap[19].b};
    check("pix_x0", 32'(pix), 32'(EXP_X0));
    pix = {cap[22].b, cap[23].b};
    check("pix_x2", 32'(pix), 32'(EXP_X2));
    pix = {cap[48].b, cap[49].b};
    check("pix_x15", 32'(pix), 32'(EXP_X15));

    bad = 0;
    for (int i = 0; i < 2*W*H; i++) begin
      e  = exp_pix((i / 2) % W);
      eb = (i % 2 == 0) ? e[15:8] : e[7:0];
      if (cap[18 + i].b !== eb || !cap[18 + i].dc) bad++;
    end
    check("pixel_bytes_bad", 32'(bad), 32'd0);

    for (int i = 0; i < 11; i++)
      check({"wrap_", exp_tab[7 + i].name}, {23'd0, cap[idx + i].dc, cap[idx + i].b},
            {23'd0, exp_tab[7 + i].dc, exp_tab[7 + i].b});

    // Long run under the protocol monitor
    k = 0;
    while (sck_rises < 8000 && k < 40000) begin
      @(posedge clk); k++;
    end
    check("sck_edge_run", 32'(sck_rises >= 8000), 32'd1);

    // Abort in the middle of a pixel byte
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!(!bus_if.spi_cs && bus_if.spi_dc && bus_if.spi_clk) && k < 500);
    check("found_pixel_byte", 32'(k < 500), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_outputs", {27'd0, bus_if.reset, bus_if.spi_cs, bus_if.spi_clk, bus_if.spi_mosi, bus_if.spi_dc},
          32'b01000);
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst = 1'b0;
    measure_reset(n);
    check("restart_reset_rise", 32'(n), 32'(RC));
    wait_cap(2, 3000, ok);
    check("wait_restart", 32'(ok), 32'd1);
    check("restart_C01", {23'd0, cap[0].dc, cap[0].b}, {23'd0, 1'b0, 8'h01});
    check("restart_C11", {23'd0, cap[1].dc, cap[1].b}, {23'd0, 1'b0, 8'h11});

    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL protocol: %0d violations (first %s), expected 0", viol, first_viol);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/st7735.md
# st7735

SPI display driver for an ST7735 128×160 TFT panel. After reset it pulses the panel reset line, then sends a fixed initialisation command sequence. It then streams full RGB565 frames forever over a write-only 4-wire SPI link (CS, DC, SCK, MOSI). It sits at the top-level pin boundary and needs no host interface.

## Interface
- `CLK_DIV`, 2: `clk` cycles per SPI half-period; must be ≥ 1.
- `RESET_CYCLES`, 1000: `clk` cycles the panel reset is held low.
- `DELAY_CYCLES`, 2000: post-reset / post-SWRESET / post-SLPOUT wait in `clk` cycles. Use 12_000_000 on silicon at 100 MHz.
- `WIDTH`, 128: columns.
- `HEIGHT`, 160: rows.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high block reset.
- `reset` output 1: panel RESX, active-low.
- `spi_cs` output 1: chip select, active-low.
- `spi_dc` output 1: 0 = command byte, 1 = data byte.
- `spi_clk` output 1: SCK, idle low.
- `spi_mosi` output 1: serial data, MSB first.

## Operation
- Reset values while `rst`=1: `reset`=0, `spi_cs`=1, `spi_clk`=0, `spi_mosi`=0, `spi_dc`=0. All counters and the FSM are cleared to HW_RESET.
- FSM states:
  - HW_RESET: hold `reset`=0 for RESET_CYCLES, then → WAIT.
  - WAIT: `reset`=1, idle for DELAY_CYCLES, then → INIT.
  - INIT: step through the ROM.
  - FRAME: address window, then pixels.
- Init ROM, in order (C = command, D = data):
  - C 0x01 SWRESET, then a DELAY_CYCLES wait.
  - C 0x11 SLPOUT, then a DELAY_CYCLES wait.
  - C 0x3A, D 0x05 (16 bpp).
  - C 0x36, D 0x00.
  - C 0x29 DISPON.
- Frame loop, repeated forever with no gap other than the inter-byte gap:
  - C 0x2A, D 0x00 0x00 0x00 WIDTH-1.
  - C 0x2B, D 0x00 0x00 0x00 HEIGHT-1.
  - C 0x2C, then WIDTH×HEIGHT pixels, 2 data bytes each, high byte first.
- Pixel order: row-major, x from 0 to WIDTH-1 fastest, y from 0 to HEIGHT-1. After the last pixel (x=WIDTH-1, y=HEIGHT-1) both wrap to 0 and the frame loop restarts at 0x2A.
- `spi_dc` is valid for the whole byte and changes only while `spi_cs`=1.
- `rst` asserted mid-byte or mid-frame aborts immediately to the reset values. The full sequence restarts at HW_RESET, including the panel reset pulse.

## Timing
- SPI mode 0:
  - MOSI is updated while SCK is low.
  - The panel samples MOSI on the SCK rising edge.
  - Each SCK half-period is CLK_DIV `clk` cycles.
- Per byte:
  - `spi_cs` falls and bit 7 is placed on MOSI.
  - 8 SCK pulses follow, each low for CLK_DIV and then high for CLK_DIV cycles.
  - After the 8th pulse, SCK returns low and `spi_cs` rises.
  - `spi_cs` is then held high for CLK_DIV cycles before the next byte.
- Byte period is exactly 17×CLK_DIV `clk` cycles.
- No SCK edges occur during HW_RESET, WAIT or the post-command delays.
- First `spi_cs` fall occurs RESET_CYCLES+DELAY_CYCLES cycles after `rst` deasserts (±1).

## Configuration
- `ST7735_COLORBAR_EN` defined: pixel colour is a function of x only, in 8 vertical bars of WIDTH/8 columns each. Bar colours in RGB565, left to right:
  - 0xFFFF white, 0xFFE0 yellow, 0x07FF cyan, 0x07E0 green.
  - 0xF81F magenta, 0xF800 red, 0x001F blue, 0x0000 black.
- Macro undefined: every pixel is 0x001F (solid blue).

## Structure
- Shared package `st7735_pkg`:
  - command opcode constants (SWRESET, SLPOUT, COLMOD, MADCTL, DISPON, CASET, RASET, RAMWR);
  - FSM state enum;
  - init-ROM entry type {is_data, is_delay, byte};
  - colour-bar constants.
- Sub-module `st7735_spi_tx`: byte serializer with `start`/`busy`/`done`, inputs `byte` and `dc`, owning SCK/CS/MOSI and the CLK_DIV divider. The top level holds the FSM, ROM, pixel counters and colour generator.

## Test plan
- Reset check: with `rst`=1, outputs read `reset`=0, `spi_cs`=1, `spi_clk`=0. After release, `reset` rises exactly RESET_CYCLES later.
- Init decode: capture bytes on SCK rising edges, tagged with DC. The first 7 captured bytes are C01, C11, C3A, D05, C36, D00, C29, with ≥ DELAY_CYCLES idle after C01 and after C11.
- Frame header: the first frame begins C2A D00 D00 D00 D7F C2B D00 D00 D00 D9F C2C.
- Pixel count: exactly 40960 data bytes follow C2C before the next C2A. With `ST7735_COLORBAR_EN` and defaults, pixel x=0 is 0xFFFF, x=16 is 0xFFE0 and x=127 is 0x0000.
- SPI timing: with CLK_DIV=2, each byte spans 34 `clk` cycles, SCK high time is 2 cycles, and MOSI is stable across every SCK rising edge. Run ≥ 30000 SCK rising edges with no protocol violation.
- Mid-stream reset: assert `rst` mid-pixel-byte. Outputs return to reset values within the same cycle and the sequence restarts at C01 after the panel reset pulse.
